// File: rtl/spybuffer_event_arbiter.sv
// Round-robin, event-atomic merge of N_INPUTS input spybuffers into one downstream stream.
// Latency: one idle cycle to grant, then read strobe to out_data in 2 cycles, 1 word/cycle per event.
// Backpressure: out_almost_full blocks new reads only; a read already issued still lands downstream.
module spybuffer_event_arbiter #(
  parameter int DATA_WIDTH = 65,
  parameter int N_INPUTS   = 4,
  parameter int CNT_WIDTH  = 32,
  localparam int GW        = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic                           enable,
  input  logic [N_INPUTS-1:0]            in_empty,
  input  logic [N_INPUTS*DATA_WIDTH-1:0] in_data,
  output logic [N_INPUTS-1:0]            in_read_enable,
  input  logic                           out_almost_full,
  output logic [DATA_WIDTH-1:0]          out_data,
  output logic                           out_write_enable,
  output logic [GW-1:0]                  grant,
  output logic                           busy,
  output logic [CNT_WIDTH-1:0]           word_count,
  output logic [CNT_WIDTH-1:0]           event_count
);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t                state, state_nxt;
  logic [GW-1:0]         rr_ptr;
  logic                  rd_pending;
  logic [DATA_WIDTH-1:0] grant_data;
  logic                  grant_empty;
  logic                  eoe_now;
  logic                  rd_go;
  logic                  start;
  logic [GW-1:0]         pick_hi, pick_lo, pick;
  logic                  hi_vld, lo_vld;

  // Round-robin search: first non-empty channel above rr_ptr, else first at or below it.
  always_comb begin
    pick_hi = '0;
    pick_lo = '0;
    hi_vld  = 1'b0;
    lo_vld  = 1'b0;
    for (int i = 0; i < N_INPUTS; i++) begin
      if (!in_empty[i] && (i > int'(rr_ptr)) && !hi_vld) begin
        pick_hi = GW'(i);
        hi_vld  = 1'b1;
      end
      if (!in_empty[i] && (i <= int'(rr_ptr)) && !lo_vld) begin
        pick_lo = GW'(i);
        lo_vld  = 1'b1;
      end
    end
    pick = hi_vld ? pick_hi : pick_lo;
  end

  always_comb begin
    grant_data  = '0;
    grant_empty = 1'b1;
    for (int i = 0; i < N_INPUTS; i++) begin
      if (grant == GW'(i)) begin
        grant_data  = in_data[i*DATA_WIDTH +: DATA_WIDTH];
        grant_empty = in_empty[i];
      end
    end
  end

  // Once the EOE word is on the buffer output, stop reading so the next event stays queued.
  assign eoe_now = rd_pending && grant_data[DATA_WIDTH-1];
  assign rd_go   = (state == STREAM) && !grant_empty && !out_almost_full && !eoe_now;
  assign start   = (state == IDLE) && enable && (hi_vld || lo_vld);
  assign busy    = (state == STREAM);

  always_comb begin
    in_read_enable = '0;
    for (int i = 0; i < N_INPUTS; i++) begin
      if (rd_go && (grant == GW'(i))) in_read_enable[i] = 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = STREAM;
      STREAM:  if (eoe_now) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state            <= IDLE;
      grant            <= '0;
      rr_ptr           <= GW'(N_INPUTS - 1);
      rd_pending       <= 1'b0;
      out_data         <= '0;
      out_write_enable <= 1'b0;
      word_count       <= '0;
      event_count      <= '0;
    end else begin
      state            <= state_nxt;
      rd_pending       <= rd_go;
      out_write_enable <= rd_pending;
      if (start) begin
        grant  <= pick;
        rr_ptr <= pick;
      end
      if (rd_pending) begin
        out_data   <= grant_data;
        word_count <= word_count + CNT_WIDTH'(1);
        if (grant_data[DATA_WIDTH-1]) event_count <= event_count + CNT_WIDTH'(1);
      end
    end
  end

endmodule
